// File: rtl/shift_result_stage.sv
// Result stage for the shift/rotate units: selects a unit result by opcode, derives flags,
// and buffers entries in a 2-deep elastic FIFO with registered head outputs.
module shift_result_stage #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             clear,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [31:0]      data_in,
    input  logic [31:0]      shift_val,
    input  logic [31:0]      res_shl,
    input  logic [31:0]      res_shr,
    input  logic [31:0]      res_shra,
    input  logic [31:0]      res_rol,
    input  logic [31:0]      res_ror,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      z_out,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_r,
    output logic             flag_ill,

    output logic [CNT_W-1:0] ops_done
);

    typedef struct packed {
        logic [31:0] result;
        logic        z;
        logic        n;
        logic        c;
        logic        r;
        logic        ill;
    } entry_t;

    localparam logic [2:0] OP_SHL  = 3'd0;
    localparam logic [2:0] OP_SHR  = 3'd1;
    localparam logic [2:0] OP_SHRA = 3'd2;
    localparam logic [2:0] OP_ROL  = 3'd3;
    localparam logic [2:0] OP_ROR  = 3'd4;

    localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

    // ------------------------------------------------------------------
    // Result selection and flag derivation
    // ------------------------------------------------------------------
    logic [31:0] sel_result;
    logic        legal;
    logic        carry;
    logic        amt_zero;
    logic        amt_le32;
    logic        amt_ge32;
    logic [4:0]  shr_idx;
    logic [4:0]  shl_idx;
    entry_t      new_entry;

    always_comb begin
        sel_result = '0;
        legal      = 1'b1;
        case (op)
            OP_SHL:  sel_result = res_shl;
            OP_SHR:  sel_result = res_shr;
            OP_SHRA: sel_result = res_shra;
            OP_ROL:  sel_result = res_rol;
            OP_ROR:  sel_result = res_ror;
            default: legal = 1'b0;
        endcase
    end

    assign amt_zero = (shift_val == 32'd0);
    assign amt_le32 = (shift_val <= 32'd32);
    assign amt_ge32 = (shift_val >= 32'd32);

    // For amounts 1..32, shr_idx = a-1 and shl_idx = 32-a = ~(a-1) in five bits.
    assign shr_idx = shift_val[4:0] - 5'd1;
    assign shl_idx = ~shr_idx;

    always_comb begin
        carry = 1'b0;
        case (op)
            OP_SHL:  carry = ~amt_zero & amt_le32 & data_in[shl_idx];
            OP_SHR:  carry = ~amt_zero & amt_le32 & data_in[shr_idx];
            OP_SHRA: begin
                if (amt_zero) begin
                    carry = 1'b0;
                end else if (amt_ge32) begin
                    carry = data_in[31];
                end else begin
                    carry = data_in[shr_idx];
                end
            end
            OP_ROL:  carry = ~amt_zero & ~amt_ge32 & sel_result[0];
            OP_ROR:  carry = ~amt_zero & ~amt_ge32 & sel_result[31];
            default: carry = 1'b0;
        endcase
    end

    always_comb begin
        new_entry.result = sel_result;
        new_entry.z      = (sel_result == 32'd0);
        new_entry.n      = sel_result[31];
        new_entry.c      = legal & carry;
        new_entry.r      = legal & (shift_val > 32'd31);
        new_entry.ill    = ~legal;
    end

    // ------------------------------------------------------------------
    // Two-entry FIFO with a registered copy of the head entry
    // ------------------------------------------------------------------
    entry_t           mem_q [2];
    entry_t           mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    entry_t           head_q, head_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] ops_q, ops_d;
    logic             push;
    logic             pop;

    assign in_ready = (count_q < FULL_COUNT) & ~clear;
    assign push     = in_valid & in_ready;
    assign pop      = valid_q & out_ready;

    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ops_d    = ops_q;

        if (push) begin
            mem_d[wr_ptr_q] = new_entry;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            ops_d    = ops_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // Looking through mem_d lets a same-cycle push become head with no extra latency.
        valid_d = (count_d != 2'd0);
        head_d  = valid_d ? mem_d[rd_ptr_d] : '0;
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            head_q   <= '0;
            valid_q  <= 1'b0;
            ops_q    <= '0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
            ops_q    <= ops_d;
        end
    end

    assign out_valid = valid_q;
    assign z_out     = head_q.result;
    assign flag_z    = head_q.z;
    assign flag_n    = head_q.n;
    assign flag_c    = head_q.c;
    assign flag_r    = head_q.r;
    assign flag_ill  = head_q.ill;
    assign ops_done  = ops_q;

endmodule

// File: doc/shift_result_stage.md
# shift_result_stage

Registered result stage directly downstream of the shift_left, shift_right, arithmetic_shift_right, rotate_left and rotate_right units in the datapath ALU. It takes the five parallel combinational results plus the original operands, selects one by opcode, and derives zero/negative/carry/range flags. It buffers results in a 2-entry elastic FIFO with valid/ready handshakes on both sides, so the Z-register writeback can stall without losing results. It also counts completed operations.

## Interface
- DEPTH, 2, FIFO entries; fixed at 2, no other value supported.
- CNT_W, 16, width of the completed-operation counter.

- clock  in  1  single system clock, all state on rising edge.
- clear  in  1  asynchronous active-high reset.
- in_valid  in  1  upstream presents a shift/rotate operation.
- in_ready  out  1  stage can accept; transfer when in_valid & in_ready at rising edge.
- op  in  3  0 SHL, 1 SHR, 2 SHRA, 3 ROL, 4 ROR, 5–7 illegal.
- data_in  in  32  operand fed to the shift units.
- shift_val  in  32  shift/rotate amount fed to the shift units.
- res_shl, res_shr, res_shra, res_rol, res_ror  in  32 each  unit outputs for the current operands.
- out_valid  out  1  head entry valid.
- out_ready  in  1  Z writeback accepts; pop when out_valid & out_ready.
- z_out  out  32  selected result of head entry.
- flag_z, flag_n, flag_c, flag_r, flag_ill  out  1 each  zero, negative, carry, range, illegal-op flags of head entry.
- ops_done  out  CNT_W  count of popped entries.

## Operation
- On accept, compute and push entry {result, Z, N, C, R, ILL}:
  - result = res_* selected by op; 0 for illegal op.
  - Z = (result == 0).
  - N = result[31].
  - R = (shift_val > 31) for every legal op. R = 0 for illegal op.
  - ILL = 1 only for op 5–7.
- Carry, with a = shift_val:
  - SHL: a in 1..32 → C = data_in[32−a]; otherwise C = 0.
  - SHR: a in 1..32 → C = data_in[a−1]; otherwise C = 0.
  - SHRA: a in 1..31 → C = data_in[a−1]; a ≥ 32 → C = data_in[31]; a = 0 → C = 0.
  - ROL: a in 1..31 → C = result[0]; otherwise C = 0.
  - ROR: a in 1..31 → C = result[31]; otherwise C = 0.
- The stage passes unit results through unchanged, including rotates with a ≥ 32. The consumer qualifies them with flag_r.
- FIFO:
  - 2 entries, count 0..2, read/write pointers wrap 1 → 0.
  - in_ready = (count < 2) & ~clear.
  - Push with no pop: count+1. Pop with no push: count−1.
  - Push and pop in the same cycle: count unchanged; the head advances and the new entry lands at the tail.
  - At count = 2, in_ready = 0, so no push occurs, even if a pop happens that cycle.
  - At count = 1 with simultaneous push and pop: the pushed entry becomes head after the edge.
- ops_done increments by 1 on each pop and wraps from 2^CNT_W−1 to 0.
- While out_valid = 0, z_out and all flags are held at 0.

## Timing
- Reset (clear high, asynchronous), outputs go immediately to:
  - count = 0, pointers = 0, entries cleared.
  - out_valid = 0, z_out = 0, all flags = 0, ops_done = 0, in_ready = 0.
- Reset mid-operation discards all buffered entries; no pop is counted.
- in_ready rises in the first cycle after clear deasserts.
- Latency: an entry accepted at edge k appears with out_valid = 1 immediately after edge k, i.e. 1 cycle.
- out_valid, z_out and flags are register outputs. in_ready depends only on count and clear; it has no combinational path from out_ready.
- Throughput is 1 op/cycle when out_ready is held high.
- Holding: while out_valid & ~out_ready, z_out and all flags stay stable.
- A pop at edge k exposes the next entry (or out_valid = 0) after edge k.

## Test plan
- Reset/basic: clear mid-stream with count = 2 → out_valid = 0, ops_done = 0, in_ready = 0 during clear and 1 the cycle after. Then SHL with data_in = 0x8000_0001, a = 1, res_shl = 0x0000_0002 → z_out = 0x2, C = 1, Z = 0, N = 0, R = 0, one cycle later.
- Shift carries and range:
  - SHRA with data_in = 0x8000_0000, a = 40, res = 0xFFFF_FFFF → C = 1, N = 1, R = 1.
  - SHR with data_in = 0x1, a = 1, res = 0 → Z = 1, C = 1.
- Rotate/illegal:
  - ROR with data_in = 0x1, a = 1, res = 0x8000_0000 → C = 1, N = 1.
  - op = 6 → z_out = 0, ILL = 1, Z = 1, R = 0.
- Backpressure: out_ready = 0 while pushing 3 ops → in_ready = 0 after 2 accepts and the third is held upstream. Then out_ready = 1 → outputs appear in order, ops_done = 3.
- Simultaneous push/pop:
  - count = 1, push and pop each cycle for 10 cycles → count stays 1, no loss or reordering.
  - count = 2 with out_ready = 1 → no push that cycle.
- Counter wrap: CNT_W = 4, 17 pops → ops_done = 1.
